mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shared-memory arbiter that sits between the instruction cache, the data cache (`dcache`) and the single external memory port of the RV64I core. It accepts one outstanding request from each cache and grants the memory to one of them at a time using round-robin arbitration. It sequences each access as issue → wait for `m_ready` → acknowledge, and enforces a watchdog timeout on the memory response.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 64, data width
- `TIMEOUT`, 255, maximum WAIT cycles before the watchdog fires (1..255; 8-bit counter)

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `i_req`  in  1  icache read request
- `i_addr`  in  ADDR_W  icache read address
- `i_rdata`  out  DATA_W  read data to icache, valid in the `i_ack` cycle
- `i_ack`  out  1  one-cycle completion pulse to icache
- `d_req`  in  1  dcache request
- `d_we`  in  8  byte-write enables; 8'h00 = read, nonzero = write
- `d_addr`  in  ADDR_W  dcache address
- `d_wdata`  in  DATA_W  dcache write data
- `d_rdata`  out  DATA_W  read data to dcache, valid in the `d_ack` cycle
- `d_ack`  out  1  one-cycle completion pulse to dcache
- `m_addr`  out  ADDR_W  memory address
- `m_wdata`  out  DATA_W  memory write data
- `m_rden`  out  1  memory read strobe, one cycle
- `m_wren`  out  8  memory byte-write strobe, one cycle
- `m_rdata`  in  DATA_W  memory read data, valid when `m_ready`=1
- `m_ready`  in  1  memory completion
- `busy`  out  1  high whenever the FSM is not in IDLE
- `timeout_err`  out  1  sticky; set on watchdog expiry, cleared only by `rst`

## Operation
- All outputs are registered. Reset value of every output is 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**: sample `i_req` and `d_req`.
  - If only one is high, grant it.
  - If both are high, grant the side opposite `last_gnt`.
  - `last_gnt` resets to I, so dcache wins the first tie.
  - On a grant: latch owner, address, `d_we` and `d_wdata` (icache grants force write enables to 0), update `last_gnt`, go to ISSUE.
- **ISSUE** (exactly 1 cycle):
  - Drive `m_addr`/`m_wdata` from the latched values.
  - Assert `m_rden`=1 if write enables are 0; otherwise assert `m_wren`=latched `d_we`.
  - Clear the counter and go to WAIT.
- **WAIT**: strobes are 0. `m_addr`/`m_wdata` hold their values.
  - If `m_ready`=1: capture `m_rdata` into the owner's rdata register (write transactions capture 0) and go to RESP.
  - Otherwise increment the counter. When the counter == TIMEOUT with no `m_ready`: set `timeout_err`, rdata = 0, go to RESP.
- **RESP** (1 cycle): pulse the owner's ack with rdata valid, then go to IDLE. The rdata registers hold their value until the next capture.
- `m_ready` outside WAIT is ignored. A request still high in the cycle after ack is treated as a new request.
- Requester protocol: hold req and operands stable until ack. If req drops mid-transaction, the transaction still completes and ack still pulses.
- A new request arriving while busy waits. No queueing beyond the one pending req line per side.
- `rst` asserted in any state: next edge returns to IDLE. The in-flight transaction is dropped with no ack and no strobe, and `last_gnt` returns to I.

## Timing
- Request high at cycle 0 in IDLE:
  - cycle 1: ISSUE, strobe visible.
  - cycle 2: first WAIT cycle.
  - `m_ready` sampled high at cycle k ≥ 2 → ack at cycle k+1.
  - Minimum latency is req-to-ack = 3 cycles.
- Watchdog: with `m_ready` never high, ack occurs at cycle 2+TIMEOUT+1 and `timeout_err` rises in the same cycle as ack.
- Back-to-back with both requesters continuously asserting: grants alternate D, I, D, I…, with one idle cycle between the RESP of one transaction and the ISSUE of the next.
- Strobes never overlap, and each is high for exactly one cycle per transaction.

## Test plan
- Reset, then `d_req`=1 read at 0x0000_0040 with `m_ready` at cycle 2 and `m_rdata`=0xDEAD_BEEF_0123_4567 → `m_rden` at cycle 1 with `m_addr`=0x40; `d_ack`=1 and `d_rdata`=0xDEAD_BEEF_0123_4567 at cycle 3; `i_ack` stays 0.
- `i_req` and `d_req` both high continuously, `m_ready` 2 cycles after each issue → grant order D, I, D, I; each ack is a single cycle; `m_wren` is never nonzero on I grants.
- dcache write with `d_we`=8'h0F, `d_addr`=0x100, `d_wdata`=0x1122334455667788 → one cycle of `m_wren`=8'h0F with matching `m_addr`/`m_wdata`; `m_rden`=0; `d_rdata`=0 at ack.
- TIMEOUT=4 and `m_ready` held 0 → ack at cycle 7 with rdata 0; `timeout_err`=1 and stays 1 across later successful transactions until `rst`.
- `rst` pulsed during WAIT → next cycle all outputs 0, no ack emitted; a subsequent simultaneous request is granted to D first.
- `m_ready` held high from cycle 0 → ignored during ISSUE; ack still at cycle 3 (captured in the first WAIT cycle).

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the icache, dcache and external-memory signals seen by mem_arbiter.
// slave = arbiter view, master = the caches and memory driving it.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  // Handshake: a cache holds req and operands stable until its one-cycle ack;
  // rdata is valid in the ack cycle. Memory answers a strobe with m_ready
  // (and m_rdata for reads), which only counts while the arbiter is waiting.
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ack;
  logic              d_req;
  logic [7:0]        d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_rden;
  logic [7:0]        m_wren;
  logic [DATA_W-1:0] m_rdata;
  logic              m_ready;
  logic              busy;
  logic              timeout_err;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
    output i_rdata, i_ack, d_rdata, d_ack, m_addr, m_wdata, m_rden, m_wren,
           busy, timeout_err
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
    input  i_rdata, i_ack, d_rdata, d_ack, m_addr, m_wdata, m_rden, m_wren,
           busy, timeout_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving the icache and dcache turns on one memory port,
// with a watchdog on the memory response. All outputs are registered.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus,
  output logic [1:0]   o_dbg_state
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            r_state, w_nxt;
  logic              r_last_d;   // 1 = dcache held the last grant
  logic              r_owner_d;
  logic [7:0]        r_we;
  logic [7:0]        r_cnt;
  logic [ADDR_W-1:0] r_m_addr;
  logic [DATA_W-1:0] r_m_wdata;
  logic              r_m_rden;
  logic [7:0]        r_m_wren;
  logic [DATA_W-1:0] r_i_rdata, r_d_rdata;
  logic              r_i_ack, r_d_ack;
  logic              r_busy, r_timeout_err;
  logic              w_gnt_d, w_gnt_i, w_tmo;
  logic [DATA_W-1:0] w_cap;

  always_comb begin
    w_nxt   = r_state;
    w_gnt_d = 1'b0;
    w_gnt_i = 1'b0;
    w_tmo   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_gnt_d = bus.d_req && (!bus.i_req || !r_last_d);
        w_gnt_i = bus.i_req && !w_gnt_d;
        if (w_gnt_d || w_gnt_i) w_nxt = S_ISSUE;
      end
      S_ISSUE: w_nxt = S_WAIT;
      S_WAIT: begin
        w_tmo = !bus.m_ready && (r_cnt == 8'(TIMEOUT));
        if (bus.m_ready || w_tmo) w_nxt = S_RESP;
      end
      S_RESP:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // Writes and watchdog expiries hand the owner zero instead of bus data.
  assign w_cap = (bus.m_ready && r_we == 8'h00) ? bus.m_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_last_d      <= 1'b0;
      r_owner_d     <= 1'b0;
      r_we          <= '0;
      r_cnt         <= '0;
      r_m_addr      <= '0;
      r_m_wdata     <= '0;
      r_m_rden      <= 1'b0;
      r_m_wren      <= '0;
      r_i_rdata     <= '0;
      r_d_rdata     <= '0;
      r_i_ack       <= 1'b0;
      r_d_ack       <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_busy   <= (w_nxt != S_IDLE);
      r_m_rden <= 1'b0;
      r_m_wren <= '0;
      r_i_ack  <= 1'b0;
      r_d_ack  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_gnt_d || w_gnt_i) begin
            r_owner_d <= w_gnt_d;
            r_last_d  <= w_gnt_d;
            r_we      <= w_gnt_d ? bus.d_we : 8'h00;
            r_m_addr  <= w_gnt_d ? bus.d_addr : bus.i_addr;
            r_m_wdata <= w_gnt_d ? bus.d_wdata : '0;
            r_m_rden  <= w_gnt_i || (bus.d_we == 8'h00);
            r_m_wren  <= w_gnt_d ? bus.d_we : 8'h00;
          end
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          if (bus.m_ready || w_tmo) begin
            if (r_owner_d) begin
              r_d_rdata <= w_cap;
              r_d_ack   <= 1'b1;
            end else begin
              r_i_rdata <= w_cap;
              r_i_ack   <= 1'b1;
            end
            if (w_tmo) r_timeout_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.m_addr      = r_m_addr;
  assign bus.m_wdata     = r_m_wdata;
  assign bus.m_rden      = r_m_rden;
  assign bus.m_wren      = r_m_wren;
  assign bus.i_rdata     = r_i_rdata;
  assign bus.d_rdata     = r_d_rdata;
  assign bus.i_ack       = r_i_ack;
  assign bus.d_ack       = r_d_ack;
  assign bus.busy        = r_busy;
  assign bus.timeout_err = r_timeout_err;
  assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT=4): reads, writes, round-robin,
// watchdog, reset mid-transaction and m_ready held early.
module tb_mem_arbiter;
  localparam int W = 64;
  localparam logic [31:0] I_ADDR = 32'h0000_1000;
  localparam logic [31:0] D_ADDR = 32'h0000_2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] dbg_state;
  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(64)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "simulation time limit");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = '0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.m_rdata = '0; bus.m_ready = 1'b0;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    while (!(bus.m_rden || bus.m_wren != 8'h00) && n < 20) begin
      tick();
      n++;
    end
  endtask

  initial begin : stim
    int n;
    logic [W-1:0] exp;
    logic is_d;
    idle_inputs();

    // reset state
    rst = 1'b1;
    tick(); tick();
    check("rst_state", dbg_state, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_acks", {bus.i_ack, bus.d_ack}, 0);
    check("rst_strobes", {bus.m_rden, bus.m_wren}, 0);
    check("rst_terr", bus.timeout_err, 0);
    rst = 1'b0;
    tick();

    // dcache read, m_ready at cycle 2
    bus.d_req = 1'b1; bus.d_addr = 32'h40; bus.d_we = 8'h00;
    tick();
    check("rd_rden", bus.m_rden, 1);
    check("rd_addr", bus.m_addr, 64'h40);
    check("rd_busy", bus.busy, 1);
    tick();
    check("rd_rden_once", bus.m_rden, 0);
    bus.m_ready = 1'b1; bus.m_rdata = 64'hDEAD_BEEF_0123_4567;
    tick();
    bus.m_ready = 1'b0; bus.d_req = 1'b0;
    check("rd_dack", bus.d_ack, 1);
    check("rd_iack", bus.i_ack, 0);
    check("rd_data", bus.d_rdata, 64'hDEAD_BEEF_0123_4567);
    tick();
    check("rd_ack_once", bus.d_ack, 0);
    check("rd_idle", bus.busy, 0);

    // dcache write
    bus.d_req = 1'b1; bus.d_we = 8'h0F; bus.d_addr = 32'h100;
    bus.d_wdata = 64'h1122_3344_5566_7788;
    tick();
    check("wr_wren", bus.m_wren, 8'h0F);
    check("wr_rden", bus.m_rden, 0);
    check("wr_addr", bus.m_addr, 64'h100);
    check("wr_wdata", bus.m_wdata, 64'h1122_3344_5566_7788);
    tick();
    check("wr_wren_once", bus.m_wren, 0);
    check("wr_addr_hold", bus.m_addr, 64'h100);
    bus.m_ready = 1'b1; bus.m_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    bus.m_ready = 1'b0; bus.d_req = 1'b0; bus.d_we = 8'h00;
    check("wr_dack", bus.d_ack, 1);
    check("wr_rdata_zero", bus.d_rdata, 0);
    tick();

    // m_ready held high from cycle 0 (icache read)
    bus.i_req = 1'b1; bus.i_addr = 32'h200;
    bus.m_ready = 1'b1; bus.m_rdata = 64'hCAFE_0000_0000_0001;
    tick();
    check("early_rden", bus.m_rden, 1);
    check("early_no_ack", bus.i_ack, 0);
    tick();
    check("early_wait_no_ack", bus.i_ack, 0);
    tick();
    bus.m_ready = 1'b0; bus.i_req = 1'b0;
    check("early_iack", bus.i_ack, 1);
    check("early_data", bus.i_rdata, 64'hCAFE_0000_0000_0001);
    tick();

    // round-robin with both requesters held high
    exp_q.push_back(W'(D_ADDR)); exp_q.push_back(W'(I_ADDR));
    exp_q.push_back(W'(D_ADDR)); exp_q.push_back(W'(I_ADDR));
    bus.i_addr = I_ADDR; bus.d_addr = D_ADDR; bus.d_we = 8'hFF;
    bus.d_wdata = 64'h5555_AAAA_5555_AAAA;
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    for (int t = 0; t < 4; t++) begin
      wait_strobe(n);
      check("rr_gap", W'(n), 1);
      exp = exp_q.pop_front();
      is_d = (exp == W'(D_ADDR));
      check("rr_owner", bus.m_addr, exp);
      check("rr_wren", bus.m_wren, is_d ? 64'hFF : 64'h00);
      check("rr_rden", bus.m_rden, is_d ? 64'h0 : 64'h1);
      tick(); tick();
      bus.m_ready = 1'b1; bus.m_rdata = 64'hA0 + W'(t);
      tick();
      bus.m_ready = 1'b0;
      if (t == 3) begin
        bus.i_req = 1'b0; bus.d_req = 1'b0;
      end
      check("rr_dack", bus.d_ack, is_d ? 64'h1 : 64'h0);
      check("rr_iack", bus.i_ack, is_d ? 64'h0 : 64'h1);
      if (!is_d) check("rr_idata", bus.i_rdata, 64'hA0 + W'(t));
      tick();
      check("rr_ack_once", {bus.i_ack, bus.d_ack}, 0);
    end
    bus.d_we = 8'h00;

    // watchdog: icache read, m_ready never high
    bus.i_req = 1'b1; bus.i_addr = 32'h300;
    for (int c = 1; c <= 6; c++) begin
      tick();
      check("wd_no_ack", bus.i_ack, 0);
    end
    check("wd_terr_low", bus.timeout_err, 0);
    tick();
    bus.i_req = 1'b0;
    check("wd_ack_c7", bus.i_ack, 1);
    check("wd_rdata", bus.i_rdata, 0);
    check("wd_terr", bus.timeout_err, 1);
    tick();

    // successful transaction after timeout; flag stays sticky
    bus.d_req = 1'b1; bus.d_addr = 32'h48;
    tick(); tick();
    bus.m_ready = 1'b1; bus.m_rdata = 64'h0BAD_F00D_0000_0002;
    tick();
    bus.m_ready = 1'b0; bus.d_req = 1'b0;
    check("post_wd_dack", bus.d_ack, 1);
    check("post_wd_data", bus.d_rdata, 64'h0BAD_F00D_0000_0002);
    check("post_wd_terr", bus.timeout_err, 1);
    tick();

    // reset during WAIT
    bus.d_req = 1'b1; bus.d_addr = 32'h80;
    tick(); tick();
    check("rst_mid_state", dbg_state, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0; bus.d_req = 1'b0;
    check("rst_mid_acks", {bus.i_ack, bus.d_ack}, 0);
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_addr", bus.m_addr, 0);
    check("rst_mid_rdata", {bus.i_rdata, bus.d_rdata}, 0);
    check("rst_mid_terr", bus.timeout_err, 0);
    tick();
    check("rst_mid_no_late_ack", {bus.i_ack, bus.d_ack}, 0);

    // first tie after reset goes to dcache
    bus.i_req = 1'b1; bus.d_req = 1'b1; bus.i_addr = I_ADDR; bus.d_addr = D_ADDR;
    tick();
    check("rst_tie_owner", bus.m_addr, W'(D_ADDR));
    tick();
    bus.m_ready = 1'b1; bus.m_rdata = 64'h77;
    tick();
    bus.m_ready = 1'b0; bus.i_req = 1'b0; bus.d_req = 1'b0;
    check("rst_tie_dack", bus.d_ack, 1);
    check("rst_tie_data", bus.d_rdata, 64'h77);
    tick(); tick();

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
